seq_divider: RTL and testbench

- Iterative restoring integer divider for the ALU datapath; computes quotient and remainder of WIDTH-bit operands.
- Each iteration shifts the remainder/quotient pair left by 1, the mirror of the multiplier path's arithmetic right shift.
- One quotient bit per clock, with a start/done handshake toward the ALU control FSM.

---
 rtl/seq_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_divider.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// ----------------------------------------------------------------------------
// seq_divider
//   Iterative restoring integer divider. It produces one quotient bit per
//   clock. A start/done handshake connects it to the ALU control FSM.
//   An accepted start at edge 0 raises done in the cycle after edge WIDTH.
//
// Build option:
//   SIGNED_DIV_EN - adds signed_op. Two's-complement operands are divided
//                   by magnitude, then sign-corrected (truncation toward 0).
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, sampled in IDLE or DONE only
//   dividend    in   [WIDTH-1:0] captured on accepted start
//   divisor     in   [WIDTH-1:0] captured on accepted start
//   signed_op   in   two's-complement mode (SIGNED_DIV_EN only)
//   quotient    out  [WIDTH-1:0] registered result
//   remainder   out  [WIDTH-1:0] registered result
//   busy        out  high while iterating
//   done        out  one-cycle pulse, results valid
//   div_by_zero out  high with done when the captured divisor was 0
// ----------------------------------------------------------------------------
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
    input  logic             signed_op,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dbz;

    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dsr_mag;
    logic             w_neg_q;
    logic             w_neg_r;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_rem_low;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_rem_fix;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_state == S_RUN) && (r_cnt == CW'(1));

    // Operand conditioning: the core always sees magnitudes.
    always_comb begin
        w_dvd_mag = dividend;
        w_dsr_mag = divisor;
        w_neg_q   = 1'b0;
        w_neg_r   = 1'b0;
`ifdef SIGNED_DIV_EN
        if (signed_op) begin
            w_neg_r = dividend[WIDTH-1];
            w_neg_q = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            if (dividend[WIDTH-1]) w_dvd_mag = -dividend;
            if (divisor[WIDTH-1])  w_dsr_mag = -divisor;
        end
`endif
    end

    // One restoring step. The partial remainder never exceeds twice the
    // divisor, so WIDTH+1 bits hold the trial difference without overflow.
    // The MSB is the borrow.
    always_comb begin
        w_shift    = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
        w_trial    = w_shift - {1'b0, r_div};
        w_fits     = ~w_trial[WIDTH];
        w_rem_next = w_fits ? w_trial : w_shift;
        w_q_next   = {r_q[WIDTH-2:0], w_fits};
        w_rem_low  = w_rem_next[WIDTH-1:0];
    end

    // Sign correction on the final step. When the divisor is 0, the
    // remainder equals the dividend magnitude. Restoring the dividend's
    // sign therefore gives back the original dividend. The all-ones
    // quotient is left as is.
    always_comb begin
        w_q_fix   = w_q_next;
        w_rem_fix = w_rem_low;
`ifdef SIGNED_DIV_EN
        if (r_neg_q && (r_div != '0)) w_q_fix = -w_q_next;
        if (r_neg_r)                  w_rem_fix = -w_rem_low;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_div     <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dbz     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            r_dbz <= 1'b0;
            case (r_state)
                S_RUN: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        quotient  <= w_q_fix;
                        remainder <= w_rem_fix;
                        r_dbz     <= (r_div == '0);
                        r_state   <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE accept a new operation identically.
                    if (w_accept) begin
                        r_rem   <= '0;
                        r_q     <= w_dvd_mag;
                        r_div   <= w_dsr_mag;
                        r_neg_q <= w_neg_q;
                        r_neg_r <= w_neg_r;
                        r_cnt   <= CW'(WIDTH);
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state == S_RUN);
    assign done        = (r_state == S_DONE);
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (WIDTH=8). Expected results come from
//   plain integer division. Define SIGNED_DIV_EN to also exercise signed mode.
// ----------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         signed_op = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef SIGNED_DIV_EN
        .signed_op  (signed_op),
`endif
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: integer division truncating toward zero.
    function automatic void model(input logic [W-1:0] d, input logic [W-1:0] v,
                                  input logic s, output logic [W-1:0] q,
                                  output logic [W-1:0] r, output logic z);
        int sd;
        int sv;
        sd = s ? int'($signed(d)) : int'(d);
        sv = s ? int'($signed(v)) : int'(v);
        z  = (v == '0);
        if (z) begin
            q = '1;
            r = d;
        end else begin
            q = W'(sd / sv);
            r = W'(sd % sv);
        end
    endfunction

    // Runs one operation and reports what was observed:
    //   lat       - edges from accept until done (-1 on timeout)
    //   busy_bad  - cycles in which busy/done disagreed with running state
    //   hold_bad  - cycles in which results moved before done
    task automatic run_op(input logic [W-1:0] d, input logic [W-1:0] v, input logic s,
                          output int lat, output logic [W-1:0] q, output logic [W-1:0] r,
                          output logic z, output logic done_after, output logic z_after,
                          output int busy_bad, output int hold_bad);
        logic [W-1:0] q0;
        logic [W-1:0] r0;
        lat = -1;
        busy_bad = 0;
        hold_bad = 0;
        q = '0; r = '0; z = 1'b0;
        @(negedge clk);
        q0 = quotient;
        r0 = remainder;
        dividend = d; divisor = v; signed_op = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (!busy || done) busy_bad++;
        if (quotient !== q0 || remainder !== r0) hold_bad++;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                q = quotient; r = remainder; z = div_by_zero;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            if (quotient !== q0 || remainder !== r0) hold_bad++;
        end
        @(posedge clk); #1;
        done_after = done;
        z_after = div_by_zero;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_tests++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
        end
    endtask

    // Checks one operation fully against the reference model.
    task automatic test_op(input string name, input logic [W-1:0] d,
                           input logic [W-1:0] v, input logic s);
        int lat, bb, hb;
        logic [W-1:0] q, r, eq, er;
        logic z, ez, da, za;
        model(d, v, s, eq, er, ez);
        run_op(d, v, s, lat, q, r, z, da, za, bb, hb);
        n_tests++;
        if (lat !== W) begin
            n_fail++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, W);
        end
        n_tests++;
        if (q !== eq || r !== er || z !== ez) begin
            n_fail++;
            $display("FAIL %s result %h/%h s=%b: got q=%h r=%h dbz=%b want q=%h r=%h dbz=%b",
                     name, d, v, s, q, r, z, eq, er, ez);
        end
        n_tests++;
        if (bb !== 0 || hb !== 0) begin
            n_fail++;
            $display("FAIL %s busy_hold: got busy_err=%0d hold_err=%0d want 0 0", name, bb, hb);
        end
        n_tests++;
        if (da !== 1'b0 || za !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse: got done=%b dbz=%b after done, want 0 0", name, da, za);
        end
    endtask

    task automatic test_basic();
        test_op("basic_100_7", 8'd100, 8'd7, 1'b0);
        test_op("max_255_1", 8'd255, 8'd1, 1'b0);
        test_op("small_5_9", 8'd5, 8'd9, 1'b0);
        test_op("equal_200_200", 8'd200, 8'd200, 1'b0);
    endtask

    task automatic test_div_zero();
        test_op("div0_37", 8'd37, 8'd0, 1'b0);
        test_op("div0_0", 8'd0, 8'd0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend = 8'd9; divisor = 8'd3;
        c1 = -1;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin c1 = k; break; end
        end
        n_tests++;
        if (c1 !== W || quotient !== 8'd14 || remainder !== 8'd2) begin
            n_fail++;
            $display("FAIL b2b_first: got lat=%0d q=%0d r=%0d want lat=%0d q=14 r=2",
                     c1, quotient, remainder, W);
        end
        c2 = -1;
        for (int k = 1; k <= 3 * W; k++) begin
            @(posedge clk); #1;
            if (done) begin c2 = k; break; end
        end
        start = 1'b0;
        n_tests++;
        if (c2 !== W + 1 || quotient !== 8'd3 || remainder !== 8'd0) begin
            n_fail++;
            $display("FAIL b2b_second: got gap=%0d q=%0d r=%0d want gap=%0d q=3 r=0",
                     c2, quotient, remainder, W + 1);
        end
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd7; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({quotient, remainder, busy, done, div_by_zero} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got q=%h r=%h busy=%b done=%b dbz=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_op("after_reset_50_6", 8'd50, 8'd6, 1'b0);
    endtask

    task automatic test_random();
        logic [W-1:0] d, v;
        logic s;
        for (int i = 0; i < 30; i++) begin
            d = W'($urandom);
            v = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
`ifdef SIGNED_DIV_EN
            s = 1'($urandom);
`else
            s = 1'b0;
`endif
            test_op("random", d, v, s);
        end
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        test_op("s_m100_7", 8'h9C, 8'd7, 1'b1);
        test_op("s_100_m7", 8'd100, 8'hF9, 1'b1);
        test_op("s_m128_m1", 8'h80, 8'hFF, 1'b1);
        test_op("s_m5_0", 8'hFB, 8'h00, 1'b1);
        test_op("s_off_9C_7", 8'h9C, 8'd7, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_midrun();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
